// File: rtl/mem_access_unit.sv
// Memory-side access stage for the multi-cycle core: one request/ack transaction per
// controller access, with IR/MDR capture, a bounded wait and Stall back-pressure.
// Optional build macro MEM_ALIGN_CHECK_EN rejects word-misaligned accesses up front.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALUOut,
  input  logic [DATA_W-1:0] WriteData,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] MemData,
  output logic              Stall,
  output logic              Done,
  output logic              BusErr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic              dest_q;
  logic              start;
  logic              misaligned;
  logic              issue;
  logic              reject;
  logic              complete;
  logic              abort;
  logic [ADDR_W-1:0] sel_addr;

  assign start    = MemRead | MemWrite;
  assign sel_addr = IorD ? ALUOut : PC;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (sel_addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case, so no path
  // leaves a signal unassigned and no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    reject   = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    Stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          Stall = 1'b1;
          if (misaligned) begin
            reject  = 1'b1;
            state_d = DONE;
          end else begin
            issue   = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        Stall = 1'b1;
        // An ack in the final allowed cycle still completes normally.
        if (mem_ack) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (count_q == LAST_WAIT) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      Instruction <= '0;
      MemData     <= '0;
      Done        <= 1'b0;
      BusErr      <= 1'b0;
      count_q     <= '0;
      dest_q      <= 1'b0;
    end else begin
      Done <= (state_d == DONE);

      if (issue) begin
        mem_req   <= 1'b1;
        mem_addr  <= sel_addr;
        mem_we    <= MemWrite;
        mem_wdata <= WriteData;
        dest_q    <= IRWrite;
        count_q   <= '0;
      end else if (state_q == BUSY && !mem_ack) begin
        count_q <= count_q + CNT_W'(1);
      end

      if (complete || abort) mem_req <= 1'b0;

      if (complete && !mem_we) begin
        if (dest_q) Instruction <= mem_rdata;
        else        MemData     <= mem_rdata;
      end

      // Conflicting read+write requests are flagged but still proceed as a write.
      if ((issue && MemRead && MemWrite) || reject || abort) BusErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus randomized
// transactions compared against a per-transaction reference model.
module tb_mem_access_unit;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead, MemWrite, IorD, IRWrite;
  logic [ADDR_W-1:0] PC, ALUOut;
  logic [DATA_W-1:0] WriteData;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] Instruction, MemData;
  logic              Stall, Done, BusErr;

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Instruction(Instruction), .MemData(MemData),
    .Stall(Stall), .Done(Done), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural reference state.
  logic [DATA_W-1:0] m_ir, m_mdr;
  logic              m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; MemRead = 0; MemWrite = 0; mem_ack = 0;
    @(negedge clk);
    #1;
    check("rst_req",   mem_req, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_ir",    Instruction, 0);
    check("rst_mdr",   MemData, 0);
    check("rst_done",  Done, 0);
    check("rst_err",   BusErr, 0);
    check("rst_stall", Stall, 0);
    reset = 1'b0;
    m_ir = '0; m_mdr = '0; m_err = 1'b0;
  endtask

  // One controller access; waits = number of BUSY cycles before ack (>= TIMEOUT: never).
  task automatic run_txn(input bit rd, input bit wr, input bit iord, input bit irw,
                         input logic [ADDR_W-1:0] pc, input logic [ADDR_W-1:0] alu,
                         input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rdata,
                         input int waits);
    logic [ADDR_W-1:0] exp_addr;
    bit misal, acked;
    int exp_req, exp_stall;
    int n, stall_n, req_n;
    bit done_seen;

    exp_addr  = iord ? alu : pc;
    misal     = ALIGN_EN && (exp_addr[1:0] != 2'b00);
    acked     = !misal && (waits < TIMEOUT);
    exp_req   = misal ? 0 : (acked ? waits + 1 : TIMEOUT);
    exp_stall = 1 + exp_req;
    if ((rd && wr) || misal || !acked) m_err = 1'b1;
    if (acked && !wr) begin
      if (irw) m_ir = rdata;
      else     m_mdr = rdata;
    end

    @(negedge clk);
    MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
    PC = pc; ALUOut = alu; WriteData = wd; mem_ack = 1'b0;
    n = 0; stall_n = 0; req_n = 0; done_seen = 0;
    while (!done_seen && n < 3 * TIMEOUT + 5) begin
      #1;
      if (Done) done_seen = 1;
      else begin
        if (Stall) stall_n++;
        if (mem_req) begin
          check("addr",  mem_addr, exp_addr);
          check("we",    mem_we, wr);
          check("wdata", mem_wdata, wd);
          mem_ack   = (req_n == waits);
          mem_rdata = mem_ack ? rdata : $urandom;
          req_n++;
        end
        @(negedge clk);
        mem_ack = 1'b0;
      end
      n++;
    end
    check("done_seen",  done_seen, 1);
    check("done_stall", Stall, 0);
    check("done_req",   mem_req, 0);
    check("stall_cyc",  stall_n, exp_stall);
    check("req_cyc",    req_n, exp_req);
    check("ir",         Instruction, m_ir);
    check("mdr",        MemData, m_mdr);
    check("buserr",     BusErr, m_err);
    // Controller still holds the request and a stray ack arrives: both must be ignored.
    mem_ack = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    MemRead = 0; MemWrite = 0;
    #1;
    check("idle_done",  Done, 0);
    check("idle_stall", Stall, 0);
    check("idle_req",   mem_req, 0);
    check("idle_ir",    Instruction, m_ir);
    check("idle_mdr",   MemData, m_mdr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int op, w, r;
    reset = 1'b1; MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
    PC = '0; ALUOut = '0; WriteData = '0; mem_rdata = '0; mem_ack = 0;
    do_reset();

    run_txn(1, 0, 0, 1, 32'h0040_0000, $urandom, $urandom, 32'h2008_0005, 0);
    run_txn(1, 0, 1, 0, $urandom, 32'h0000_0010, $urandom, 32'hDEAD_BEEF, 3);
    run_txn(0, 1, 1, 0, $urandom, 32'h0000_0020, 32'h1234_5678, $urandom, 2);
    run_txn(1, 0, 1, 1, $urandom, 32'h0000_0100, $urandom, 32'hCAFE_0001, TIMEOUT - 1);
    run_txn(1, 0, 1, 0, $urandom, 32'h0000_0030, $urandom, 32'h5555_AAAA, TIMEOUT);
    run_txn(1, 0, 0, 1, 32'h0000_0044, $urandom, $urandom, 32'h0BAD_F00D, 1);
    run_txn(1, 0, 1, 0, $urandom, 32'h0000_0012, $urandom, 32'h7777_7777, 0);
    run_txn(1, 1, 1, 0, $urandom, 32'h0000_0050, 32'hA5A5_5A5A, $urandom, 0);

    // Reset in the middle of BUSY, then a late ack.
    do_reset();
    @(negedge clk);
    MemRead = 1; IorD = 1; IRWrite = 0; ALUOut = 32'h0000_0010;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; MemRead = 0;
    @(negedge clk);
    #1;
    check("midrst_req",   mem_req, 0);
    check("midrst_stall", Stall, 0);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("midrst_mdr",  MemData, 0);
    check("midrst_done", Done, 0);
    check("midrst_err",  BusErr, 0);
    m_ir = '0; m_mdr = '0; m_err = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 9) do_reset();
      op = $urandom_range(0, 9);
      r  = $urandom_range(0, 9);
      if (r < 7)       w = $urandom_range(0, 4);
      else if (r == 7) w = TIMEOUT - 1;
      else if (r == 8) w = TIMEOUT + $urandom_range(0, 3);
      else             w = $urandom_range(5, TIMEOUT - 2);
      a = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      run_txn(op <= 6 || op == 9, op >= 7, a[31], op <= 3, a, a, $urandom, $urandom, w);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
